// File: rtl/text_vram_arbiter.sv
// Write-port owner for the 80x30 text character RAM: round-robin arbitration between
// the terminal writer (req0) and CPU cell writes (req1), plus a full-screen clear sequencer.
`timescale 1ns/1ps
module text_vram_arbiter #(
    parameter int          COLS      = 80,
    parameter int          ROWS      = 30,
    parameter int          COL_W     = 7,
    parameter int          ROW_W     = 5,
    parameter logic [7:0]  FILL_CHAR = 8'h20
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_req0_valid,
    input  logic [ROW_W+COL_W-1:0] i_req0_addr,
    input  logic [7:0]             i_req0_data,
    output logic                   o_req0_ready,
    input  logic                   i_req1_valid,
    input  logic [ROW_W+COL_W-1:0] i_req1_addr,
    input  logic [7:0]             i_req1_data,
    output logic                   o_req1_ready,
    input  logic                   i_clear,
    output logic                   o_busy,
    output logic                   o_clear_done,
    output logic                   o_addr_err,
    output logic                   o_we,
    output logic [ROW_W+COL_W-1:0] o_address,
    output logic [7:0]             o_data
);

    localparam int AW = ROW_W + COL_W;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    typedef enum logic {
        NORM  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             rr_last;     // requester granted most recently (0 or 1)
    logic [ROW_W-1:0] clr_row;
    logic [COL_W-1:0] clr_col;
    logic             last_cell;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic [AW-1:0]    acc_addr;
    logic [7:0]       acc_data;
    logic             acc_in_range;

    // Handshake: a write transfers in any cycle where valid and ready are both high;
    // ready is combinational and never asserted while a clear is requested or running,
    // and the requester holds addr/data stable while valid is high and ready is low.
    assign last_cell = (clr_row == LAST_ROW) && (clr_col == LAST_COL);

    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        case (state)
            NORM: begin
                if (i_clear) begin
                    state_next = CLEAR;
                end else if (i_req0_valid && i_req1_valid) begin
                    grant0 = rr_last;
                    grant1 = !rr_last;
                end else begin
                    grant0 = i_req0_valid;
                    grant1 = i_req1_valid;
                end
            end
            CLEAR: begin
                if (last_cell) begin
                    state_next = NORM;
                end
            end
            default: state_next = NORM;
        endcase
    end

    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;
    assign o_busy       = (state == CLEAR);

    assign accept       = grant0 || grant1;
    assign acc_addr     = grant1 ? i_req1_addr : i_req0_addr;
    assign acc_data     = grant1 ? i_req1_data : i_req0_data;
    assign acc_in_range = (acc_addr[AW-1:COL_W] <= LAST_ROW) && (acc_addr[COL_W-1:0] <= LAST_COL);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= NORM;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_we         <= 1'b0;
            o_address    <= '0;
            o_data       <= '0;
            o_addr_err   <= 1'b0;
            o_clear_done <= 1'b0;
            rr_last      <= 1'b0;
            clr_row      <= '0;
            clr_col      <= '0;
        end else begin
            o_we         <= 1'b0;
            o_addr_err   <= 1'b0;
            o_clear_done <= 1'b0;
            if (state == CLEAR) begin
                o_we      <= 1'b1;
                o_address <= {clr_row, clr_col};
                o_data    <= FILL_CHAR;
                if (last_cell) begin
                    o_clear_done <= 1'b1;
                    clr_row      <= '0;
                    clr_col      <= '0;
                end else if (clr_col == LAST_COL) begin
                    clr_col <= '0;
                    clr_row <= clr_row + ROW_W'(1);
                end else begin
                    clr_col <= clr_col + COL_W'(1);
                end
            end else if (i_clear) begin
                clr_row <= '0;
                clr_col <= '0;
            end else if (accept) begin
                rr_last <= grant1;
                // Out-of-range requests are consumed but never reach the RAM.
                if (acc_in_range) begin
                    o_we      <= 1'b1;
                    o_address <= acc_addr;
                    o_data    <= acc_data;
                end else begin
                    o_addr_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_text_vram_arbiter.sv
// Bench for text_vram_arbiter: vector table, clear/reset corner sequences and random
// traffic, all checked against a cell-index based reference model.
`timescale 1ns/1ps
module tb_text_vram_arbiter;

    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int NCELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v0, v1, clr;
    logic [11:0] a0, a1;
    logic [7:0]  d0, d1;
    logic        r0, r1, busy, done, err, we;
    logic [11:0] address;
    logic [7:0]  data;

    always #5 clk = ~clk;

    text_vram_arbiter #(
        .COLS(80), .ROWS(30), .COL_W(7), .ROW_W(5), .FILL_CHAR(8'h20)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0_valid(v0), .i_req0_addr(a0), .i_req0_data(d0), .o_req0_ready(r0),
        .i_req1_valid(v1), .i_req1_addr(a1), .i_req1_data(d1), .o_req1_ready(r1),
        .i_clear(clr), .o_busy(busy), .o_clear_done(done), .o_addr_err(err),
        .o_we(we), .o_address(address), .o_data(data)
    );

    int tests_run = 0;
    int fails     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: screen clear tracked as a linear cell index 0..NCELLS-1.
    bit          m_clearing;
    int          m_idx;
    int          m_last;
    bit          m_r0, m_r1, m_we, m_err, m_done, m_busy;
    logic [11:0] m_addr;
    logic [7:0]  m_data;
    logic [19:0] exp_q[$];

    function automatic void model_reset();
        m_clearing = 0; m_idx = 0; m_last = 0;
        m_r0 = 0; m_r1 = 0; m_we = 0; m_err = 0; m_done = 0; m_busy = 0;
        m_addr = '0; m_data = '0;
        exp_q.delete();
    endfunction

    function automatic void model_step();
        int g;
        int row;
        int col;
        logic [11:0] ad;
        m_r0 = 0; m_r1 = 0; m_we = 0; m_err = 0; m_done = 0;
        if (m_clearing) begin
            m_addr = 12'((m_idx / COLS) * 128 + (m_idx % COLS));
            m_data = 8'h20;
            m_we   = 1;
            exp_q.push_back({m_addr, m_data});
            if (m_idx == NCELLS - 1) begin
                m_done = 1; m_clearing = 0; m_idx = 0;
            end else begin
                m_idx++;
            end
        end else if (clr) begin
            m_clearing = 1; m_idx = 0;
        end else begin
            g = -1;
            if (v0 && v1) g = 1 - m_last;
            else if (v0) g = 0;
            else if (v1) g = 1;
            if (g >= 0) begin
                m_last = g;
                if (g == 0) m_r0 = 1; else m_r1 = 1;
                ad  = (g == 1) ? a1 : a0;
                row = int'(ad) / 128;
                col = int'(ad) % 128;
                if (row < ROWS && col < COLS) begin
                    m_we = 1; m_addr = ad; m_data = (g == 1) ? d1 : d0;
                    exp_q.push_back({m_addr, m_data});
                end else begin
                    m_err = 1;
                end
            end
        end
        m_busy = m_clearing;
    endfunction

    logic s_r0, s_r1;

    // One clock: inputs already driven at the negedge; readies sampled before the
    // edge, registered outputs sampled 1ns after it.
    task automatic cycle();
        logic [19:0] e;
        #1;
        s_r0 = r0; s_r1 = r1;
        model_step();
        check("req0_ready", s_r0, m_r0);
        check("req1_ready", s_r1, m_r1);
        @(posedge clk); #1;
        check("we", we, m_we);
        check("addr_err", err, m_err);
        check("clear_done", done, m_done);
        check("busy", busy, m_busy);
        if (m_we) begin
            e = exp_q.pop_front();
            check("write_addr", address, e[19:8]);
            check("write_data", data, e[7:0]);
        end else begin
            check("held_addr", address, m_addr);
            check("held_data", data, m_data);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v0 = 0; v1 = 0; clr = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        model_reset();
        #1;
        check("reset_we", we, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_addr", address, 0);
        check("reset_data", data, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [11:0] rand_addr();
        if ($urandom_range(0, 3) != 0)
            return {5'($urandom_range(0, 29)), 7'($urandom_range(0, 79))};
        return 12'($urandom);
    endfunction

    typedef struct {
        logic v0; logic [11:0] a0; logic [7:0] d0;
        logic v1; logic [11:0] a1; logic [7:0] d1;
        logic r0; logic r1; logic we; logic [11:0] addr; logic [7:0] data; logic err;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int zero_cnt, fills, done_cnt, k1, k2;
        bit accepted;
        logic [11:0] first_addr, prev_addr, after_4f, done_addr;
        logic done_we;

        vecs[0]  = '{1'b1, 12'h10A, 8'h41, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 12'h10A, 8'h41, 1'b0};
        vecs[1]  = '{1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 12'h10A, 8'h41, 1'b0};
        vecs[2]  = '{1'b1, 12'h001, 8'h61, 1'b1, 12'h202, 8'h62, 1'b0, 1'b1, 1'b1, 12'h202, 8'h62, 1'b0};
        vecs[3]  = '{1'b1, 12'h001, 8'h61, 1'b1, 12'h202, 8'h62, 1'b1, 1'b0, 1'b1, 12'h001, 8'h61, 1'b0};
        vecs[4]  = '{1'b1, 12'h001, 8'h61, 1'b1, 12'h202, 8'h62, 1'b0, 1'b1, 1'b1, 12'h202, 8'h62, 1'b0};
        vecs[5]  = '{1'b1, 12'h001, 8'h61, 1'b1, 12'h202, 8'h62, 1'b1, 1'b0, 1'b1, 12'h001, 8'h61, 1'b0};
        vecs[6]  = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h1D5, 8'h63, 1'b0, 1'b1, 1'b0, 12'h001, 8'h61, 1'b1};
        vecs[7]  = '{1'b0, 12'h000, 8'h00, 1'b1, 12'hF00, 8'h64, 1'b0, 1'b1, 1'b0, 12'h001, 8'h61, 1'b1};
        vecs[8]  = '{1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 12'h001, 8'h61, 1'b0};
        vecs[9]  = '{1'b0, 12'h000, 8'h00, 1'b1, 12'hECF, 8'h7E, 1'b0, 1'b1, 1'b1, 12'hECF, 8'h7E, 1'b0};
        vecs[10] = '{1'b1, 12'h050, 8'h11, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 12'hECF, 8'h7E, 1'b1};
        vecs[11] = '{1'b1, 12'h04F, 8'h12, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 12'h04F, 8'h12, 1'b0};
        vecs[12] = '{1'b1, 12'h000, 8'h13, 1'b1, 12'h07F, 8'h14, 1'b0, 1'b1, 1'b0, 12'h04F, 8'h12, 1'b1};
        vecs[13] = '{1'b1, 12'h000, 8'h13, 1'b1, 12'h07F, 8'h14, 1'b1, 1'b0, 1'b1, 12'h000, 8'h13, 1'b0};
        vecs[14] = '{1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 12'h000, 8'h13, 1'b0};

        rst_n = 1'b0;
        v0 = 0; v1 = 0; clr = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 15; i++) begin
            v0 = vecs[i].v0; a0 = vecs[i].a0; d0 = vecs[i].d0;
            v1 = vecs[i].v1; a1 = vecs[i].a1; d1 = vecs[i].d1;
            clr = 0;
            cycle();
            check($sformatf("vec%0d_r0", i), s_r0, vecs[i].r0);
            check($sformatf("vec%0d_r1", i), s_r1, vecs[i].r1);
            check($sformatf("vec%0d_we", i), we, vecs[i].we);
            check($sformatf("vec%0d_addr", i), address, vecs[i].addr);
            check($sformatf("vec%0d_data", i), data, vecs[i].data);
            check($sformatf("vec%0d_err", i), err, vecs[i].err);
        end

        // One-cycle clear pulse while req0 waits.
        v0 = 1; a0 = 12'h123; d0 = 8'h55; v1 = 0; clr = 1;
        zero_cnt = 0; fills = 0; done_cnt = 0; accepted = 0;
        first_addr = '1; prev_addr = '1; after_4f = '1; done_addr = '1; done_we = 0;
        for (int k = 0; k < 3000 && !accepted; k++) begin
            cycle();
            clr = 0;
            if (s_r0) accepted = 1;
            else zero_cnt++;
            if (!s_r0 && we && data == 8'h20) begin
                fills++;
                if (fills == 1) first_addr = address;
                if (fills > 1 && prev_addr == 12'h04F) after_4f = address;
                prev_addr = address;
            end
            if (done) begin
                done_cnt++; done_addr = address; done_we = we;
            end
        end
        check("clear_accept_timeout", accepted, 1);
        check("clear_ready_low_cycles", zero_cnt, 2401);
        check("clear_fill_writes", fills, NCELLS);
        check("clear_first_addr", first_addr, 12'h000);
        check("clear_addr_after_04f", after_4f, 12'h080);
        check("clear_done_pulses", done_cnt, 1);
        check("clear_done_addr", done_addr, 12'hECF);
        check("clear_done_we", done_we, 1);
        check("post_clear_we", we, 1);
        check("post_clear_addr", address, 12'h123);
        check("post_clear_data", data, 8'h55);
        v0 = 0;
        cycle();

        // i_clear held high: back-to-back clears one NORM cycle apart.
        clr = 1; done_cnt = 0; k1 = -1; k2 = -1;
        for (int k = 0; k < 5000; k++) begin
            cycle();
            if (done) begin
                done_cnt++;
                if (k1 < 0) k1 = k; else if (k2 < 0) k2 = k;
            end
        end
        check("held_clear_done_pulses", done_cnt, 2);
        check("held_clear_first_done", k1, 2400);
        check("held_clear_second_done", k2, 4801);
        clr = 0;
        accepted = 0;
        for (int k = 0; k < 3000 && !accepted; k++) begin
            cycle();
            if (!busy) accepted = 1;
        end
        check("held_clear_drain_timeout", accepted, 1);

        // Reset in the middle of a clear.
        clr = 1;
        cycle();
        clr = 0;
        repeat (1000) cycle();
        check("mid_clear_busy", busy, 1);
        do_reset();
        v0 = 1; a0 = 12'h005; d0 = 8'h33;
        cycle();
        check("after_reset_r0", s_r0, 1);
        check("after_reset_we", we, 1);
        check("after_reset_addr", address, 12'h005);
        v0 = 0; clr = 1;
        cycle();
        clr = 0;
        cycle();
        check("restart_first_addr", address, 12'h000);
        check("restart_first_data", data, 8'h20);
        cycle();
        check("restart_second_addr", address, 12'h001);
        accepted = 0;
        for (int k = 0; k < 3000 && !accepted; k++) begin
            cycle();
            if (!busy) accepted = 1;
        end
        check("restart_drain_timeout", accepted, 1);

        // Random traffic with held requests and occasional clears.
        v0 = 0; v1 = 0;
        for (int k = 0; k < 6000; k++) begin
            if (!(v0 && !s_r0)) begin
                v0 = ($urandom_range(0, 3) != 0); a0 = rand_addr(); d0 = 8'($urandom);
            end
            if (!(v1 && !s_r1)) begin
                v1 = ($urandom_range(0, 3) != 0); a1 = rand_addr(); d1 = 8'($urandom);
            end
            clr = ($urandom_range(0, 999) == 0);
            cycle();
        end
        v0 = 0; v1 = 0; clr = 0;
        accepted = 0;
        for (int k = 0; k < 3000 && !accepted; k++) begin
            cycle();
            if (!busy) accepted = 1;
        end
        check("random_drain_timeout", accepted, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
